// File: rtl/dgwclk_enable_ctrl.sv
// Row clock-gate enable sequencer: buffers {row,len} commands and walks one
// registered enable bit across consecutive rows, with abort flush and force-all test override.
module dgwclk_enable_ctrl #(
  parameter int ROWS       = 16,
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_row,
  input  logic [AW-1:0]   cmd_len,
  input  logic            abort,
  input  logic            force_all,
  output logic [ROWS-1:0] E,
  output logic [AW-1:0]   row_idx,
  output logic            busy,
  output logic            done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  typedef struct packed {
    logic [AW-1:0] row;
    logic [AW-1:0] len;
  } cmd_t;

  cmd_t            mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_en_q, ready_en_d;
  state_t          state_q, state_d;
  logic [AW-1:0]   cur_q, cur_d, rem_q, rem_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [ROWS-1:0] e_q, e_d;
  logic [AW-1:0]   row_idx_q, row_idx_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            push, pop, start;
  cmd_t            head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [ROWS-1:0] one_hot(input logic [AW-1:0] r);
    return ROWS'(1) << r;
  endfunction

  assign cmd_ready = ready_en_q & ~abort & (count_q < CW'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr_q];

  // A command pushed into an empty FIFO while IDLE is popped on the very next
  // edge, so the 1-cycle first-row latency needs no separate bypass path.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    e_d       = e_q;
    row_idx_d = row_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start     = 1'b0;
    pop       = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      e_d       = '0;
      row_idx_d = '0;
      busy_d    = 1'b0;
    end else if (force_all) begin
      e_d = '1;
    end else begin
      e_d       = '0;
      row_idx_d = '0;
      unique case (state_q)
        IDLE: start = (count_q != '0);
        ACTIVE: begin
          if (rem_q != '0) begin
            cur_d     = cur_q + AW'(1);
            rem_d     = rem_q - AW'(1);
            e_d       = one_hot(cur_d);
            row_idx_d = cur_d;
            done_d    = (rem_q == AW'(1));
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
            start   = (count_q != '0);
          end
        end
        GAP: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else begin
            state_d = IDLE;
            start   = (count_q != '0);
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        pop       = 1'b1;
        state_d   = ACTIVE;
        cur_d     = head.row;
        rem_d     = head.len;
        e_d       = one_hot(head.row);
        row_idx_d = head.row;
        done_d    = (head.len == '0);
      end
      busy_d = (state_d != IDLE);
    end
  end

  always_comb begin
    ready_en_d = 1'b1;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      e_q        <= '0;
      row_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      e_q        <= e_d;
      row_idx_q  <= row_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read when count_q marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{row: cmd_row, len: cmd_len};
  end

  assign E       = e_q;
  assign row_idx = row_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dgwclk_enable_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_dgwclk_enable_ctrl;

  localparam int ROWS       = 16;
  localparam int AW         = 4;
  localparam int GAP_CYCLES = 1;
  localparam int FIFO_DEPTH = 2;

  logic            clk, rst, cmd_valid, cmd_ready, abort, force_all;
  logic [AW-1:0]   cmd_row, cmd_len, row_idx;
  logic [ROWS-1:0] E;
  logic            busy, done;

  dgwclk_enable_ctrl #(
    .ROWS(ROWS), .AW(AW), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_len(cmd_len), .abort(abort), .force_all(force_all),
    .E(E), .row_idx(row_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a command expands into a plan of per-cycle outputs
  // (its rows, then GAP_CYCLES idle-but-busy cycles); each unforced edge emits one.
  typedef struct { int row; int len; } mcmd_t;
  typedef struct { int row; bit is_row; bit last; } item_t;

  mcmd_t           mfifo[$];
  item_t           plan[$];
  logic [ROWS-1:0] m_e        = '0;
  logic [AW-1:0]   m_row      = '0;
  bit              m_busy     = 1'b0;
  bit              m_done     = 1'b0;
  bit              m_ready_en = 1'b0;

  task automatic model_clear();
    mfifo.delete();
    plan.delete();
    m_e    = '0;
    m_row  = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  initial begin : model
    bit    rdy, psh;
    mcmd_t c;
    item_t it;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
        m_ready_en = 1'b0;
      end else begin
        rdy = m_ready_en && !abort && (mfifo.size() < FIFO_DEPTH);
        psh = cmd_valid && rdy;
        if (abort) begin
          model_clear();
        end else if (force_all) begin
          m_e    = '1;
          m_done = 1'b0;
        end else begin
          if (plan.size() == 0 && mfifo.size() > 0) begin
            c = mfifo.pop_front();
            for (int i = 0; i <= c.len; i++) plan.push_back('{(c.row + i) % ROWS, 1'b1, (i == c.len)});
            for (int g = 0; g < GAP_CYCLES; g++) plan.push_back('{0, 1'b0, 1'b0});
          end
          m_e = '0;
          if (plan.size() > 0) begin
            it     = plan.pop_front();
            m_busy = 1'b1;
            m_done = it.last;
            m_row  = it.is_row ? AW'(it.row) : '0;
            if (it.is_row) m_e[it.row] = 1'b1;
          end else begin
            m_row  = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
          end
        end
        if (psh) mfifo.push_back('{int'(cmd_row), int'(cmd_len)});
        m_ready_en = 1'b1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #2;
      if (cmp_en) begin
        check("cyc_E", 32'(E), 32'(m_e));
        check("cyc_row_idx", 32'(row_idx), 32'(m_row));
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_cmd_ready", 32'(cmd_ready),
              32'(m_ready_en && !abort && (mfifo.size() < FIFO_DEPTH)));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input int row, input int len, output int waits);
    waits     = 0;
    cmd_valid = 1'b1;
    cmd_row   = AW'(row);
    cmd_len   = AW'(len);
    #1;
    while (!cmd_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("push_accepted", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic single_cmd_check(input string tag);
    cmd_valid = 1'b1;
    cmd_row   = 4'd3;
    cmd_len   = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_accept_E"}, 32'(E), 32'h0);
    @(negedge clk);
    check({tag, "_row3"}, 32'(E), 32'h0008);
    check({tag, "_row3_done"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_row4"}, 32'(E), 32'h0010);
    @(negedge clk);
    check({tag, "_row5"}, 32'(E), 32'h0020);
    check({tag, "_row5_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_gap_E"}, 32'(E), 32'h0);
    check({tag, "_gap_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] wrap_e    [4] = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};
  int          wrap_rows [4] = '{14, 15, 0, 1};

  initial begin : stim
    int          w, singles, ones, fleft, fcnt;
    bit          fired, seen;
    logic [15:0] prev_e, resume_e;

    rst = 1'b1; cmd_valid = 1'b0; cmd_row = '0; cmd_len = '0; abort = 1'b0; force_all = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_E", 32'(E), 32'h0);
    check("rst_row_idx", 32'(row_idx), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    single_cmd_check("single");
    repeat (3) @(negedge clk);

    cmd_valid = 1'b1; cmd_row = 4'd14; cmd_len = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_E", 32'(E), 32'(wrap_e[i]));
      check("wrap_row_idx", 32'(row_idx), 32'(wrap_rows[i]));
    end
    repeat (4) @(negedge clk);

    push_cmd(0, 3, w);
    push_cmd(4, 1, w);
    push_cmd(8, 1, w);
    push_cmd(12, 1, w);
    check("backpressure_waits", 32'(w), 32'd4);
    repeat (20) @(negedge clk);

    force_all = 1'b1; cmd_valid = 1'b1; cmd_row = 4'd6; cmd_len = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("idle_force_E", 32'(E), 32'hFFFF);
    check("idle_force_busy", 32'(busy), 32'd0);
    check("idle_force_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("idle_force_done", 32'(done), 32'd0);
    force_all = 1'b0;
    @(negedge clk);
    check("force_release_E", 32'(E), 32'h0040);
    check("force_release_done", 32'(done), 32'd1);
    repeat (4) @(negedge clk);

    push_cmd(2, 7, w);
    push_cmd(9, 0, w);
    @(negedge clk);
    check("abort_second_row", 32'(E), 32'h0008);
    abort = 1'b1;
    #1;
    check("abort_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_E", 32'(E), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (E != '0) seen = 1'b1;
    end
    check("abort_queued_dropped", 32'(seen), 32'd0);

    push_cmd(0, 9, w);
    singles = 0; ones = 0; fleft = 0; fired = 1'b0; prev_e = '0; resume_e = '0;
    for (int i = 0; i < 20; i++) begin
      if (E == '1) ones++;
      else if ($countones(E) == 1) singles++;
      if (prev_e == '1 && E != '1) resume_e = E;
      prev_e = E;
      if (force_all) begin
        fleft--;
        if (fleft == 0) force_all = 1'b0;
      end else if (!fired && E == 16'h0010) begin
        force_all = 1'b1;
        fleft     = 3;
        fired     = 1'b1;
      end
      @(negedge clk);
    end
    check("force_ones_cycles", 32'(ones), 32'd3);
    check("force_single_rows", 32'(singles), 32'd10);
    check("force_resume_row", 32'(resume_e), 32'h0020);

    push_cmd(0, 7, w);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_E", 32'(E), 32'h0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    single_cmd_check("post_rst");

    fcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 99) < 45);
      cmd_row   = AW'($urandom_range(0, ROWS - 1));
      cmd_len   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, ROWS - 1))
                                              : AW'($urandom_range(0, 3));
      abort     = ($urandom_range(0, 99) < 2);
      if (fcnt > 0) fcnt--;
      else if ($urandom_range(0, 99) < 3) fcnt = int'($urandom_range(1, 4));
      force_all = (fcnt > 0);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    cmd_valid = 1'b0; abort = 1'b0; force_all = 1'b0;
    repeat (60) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
